// File: rtl/pipe_addsub_32.sv
// Two-stage pipelined 32-bit adder/subtractor with valid/ready on both sides.
// Stage 1 registers bit and block generate/propagate; stage 2 does 4-block carry lookahead and flags.
module pipe_addsub_32 #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned BLOCK_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_ne,
  output logic             out_lt
);

  localparam int unsigned NUM_BLK = WIDTH / BLOCK_W;

  logic               s1_valid, s2_valid;
  logic [WIDTH-1:0]   s1_p, s1_g;
  logic [NUM_BLK-1:0] s1_pg, s1_gg;
  logic               s1_sub;
  logic               s1_load, s2_load;

  assign in_ready  = !s1_valid || !s2_valid || out_ready;
  assign s1_load   = in_valid && in_ready;
  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign out_valid = s2_valid;

  logic [WIDTH-1:0]   b_eff, p_d, g_d;
  logic [NUM_BLK-1:0] pg_d, gg_d;

  always_comb begin
    logic gacc;
    b_eff = in_sub ? ~in_b : in_b;
    p_d   = in_a ^ b_eff;
    g_d   = in_a & b_eff;
    pg_d  = '0;
    gg_d  = '0;
    gacc  = 1'b0;
    for (int k = 0; k < NUM_BLK; k++) begin
      pg_d[k] = &p_d[k*BLOCK_W +: BLOCK_W];
      // Block generate: carry out of the block assuming zero carry-in.
      gacc = 1'b0;
      for (int j = 0; j < BLOCK_W; j++) begin
        gacc = g_d[k*BLOCK_W+j] | (p_d[k*BLOCK_W+j] & gacc);
      end
      gg_d[k] = gacc;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_pg    <= '0;
      s1_gg    <= '0;
      s1_sub   <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_p     <= p_d;
        s1_g     <= g_d;
        s1_pg    <= pg_d;
        s1_gg    <= gg_d;
        s1_sub   <= in_sub;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Flat two-level lookahead across the four blocks; cin is the subtract flag.
  logic [NUM_BLK:0] blk_c;
  always_comb begin
    blk_c    = '0;
    blk_c[0] = s1_sub;
    blk_c[1] = s1_gg[0] | (s1_pg[0] & s1_sub);
    blk_c[2] = s1_gg[1] | (s1_pg[1] & s1_gg[0]) | (s1_pg[1] & s1_pg[0] & s1_sub);
    blk_c[3] = s1_gg[2] | (s1_pg[2] & s1_gg[1]) | (s1_pg[2] & s1_pg[1] & s1_gg[0])
             | (s1_pg[2] & s1_pg[1] & s1_pg[0] & s1_sub);
    blk_c[4] = s1_gg[3] | (s1_pg[3] & s1_gg[2]) | (s1_pg[3] & s1_pg[2] & s1_gg[1])
             | (s1_pg[3] & s1_pg[2] & s1_pg[1] & s1_gg[0])
             | (s1_pg[3] & s1_pg[2] & s1_pg[1] & s1_pg[0] & s1_sub);
  end

  logic [WIDTH-1:0] sum_d;
  logic             c_msb, ovf_d, ne_d, lt_d;

  always_comb begin
    logic cb;
    sum_d = '0;
    c_msb = 1'b0;
    cb    = 1'b0;
    for (int k = 0; k < NUM_BLK; k++) begin
      cb = blk_c[k];
      for (int j = 0; j < BLOCK_W; j++) begin
        sum_d[k*BLOCK_W+j] = s1_p[k*BLOCK_W+j] ^ cb;
        if (k == NUM_BLK - 1 && j == BLOCK_W - 1) c_msb = cb;
        cb = s1_g[k*BLOCK_W+j] | (s1_p[k*BLOCK_W+j] & cb);
      end
    end
    ovf_d = c_msb ^ blk_c[NUM_BLK];
    ne_d  = s1_sub & (|sum_d);
    lt_d  = s1_sub & (sum_d[WIDTH-1] ^ ovf_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_ne   <= 1'b0;
      out_lt   <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        out_sum  <= sum_d;
        out_cout <= blk_c[NUM_BLK];
        out_ovf  <= ovf_d;
        out_ne   <= ne_d;
        out_lt   <= lt_d;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_addsub_32.sv
// Scoreboard bench for pipe_addsub_32: arithmetic reference model, directed
// boundary cases, backpressure, async reset and a short random phase.
module tb_pipe_addsub_32;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        ne;
    logic        lt;
  } res_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_sum;
  logic        out_cout, out_ovf, out_ne, out_lt;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  bit   rand_ready = 0;

  pipe_addsub_32 dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .out_ne   (out_ne),
    .out_lt   (out_lt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    res_t        r;
    logic [32:0] full;
    if (sub) full = {1'b0, a} + {1'b0, ~b} + 33'd1;
    else     full = {1'b0, a} + {1'b0, b};
    r.sum  = full[31:0];
    r.cout = full[32];
    if (sub) r.ovf = (a[31] != b[31]) && (r.sum[31] != a[31]);
    else     r.ovf = (a[31] == b[31]) && (r.sum[31] != a[31]);
    r.ne   = sub && (a != b);
    r.lt   = sub && ($signed(a) < $signed(b));
    return r;
  endfunction

  // Output side of the scoreboard: a transfer happens at the next rising edge.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 64'(sb.size()), 64'd1);
      end else begin
        res_t e;
        e = sb.pop_front();
        check("sum", 64'(out_sum), 64'(e.sum));
        check("flags", 64'({out_cout, out_ovf, out_ne, out_lt}),
              64'({e.cout, e.ovf, e.ne, e.lt}));
      end
    end
  end

  always @(posedge clock) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub);
    bit done;
    done = 0;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clock);
      if (in_ready) begin
        sb.push_back(model(a, b, sub));
        done = 1;
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    check("send_accepted", 64'(done), 64'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && sb.size() != 0; n++) @(posedge clock);
    #1;
    check("drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_flags", 64'({out_cout, out_ovf, out_ne, out_lt}), 64'd0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    // Latency: accepted at edge N, out_valid after edge N+1
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    check("lat_n", 64'(out_valid), 64'd0);
    @(posedge clock); #1;
    check("lat_n1", 64'(out_valid), 64'd1);
    drain();

    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    send(32'd5, 32'd7, 1'b1);
    send(32'd9, 32'd9, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 1'b1);
    send(32'h0000_0001, 32'h8000_0000, 1'b1);
    drain();

    // Backpressure: two buffered, third refused, output held
    out_ready = 1'b0;
    in_valid = 1'b1; in_sub = 1'b0;
    in_a = 32'd1; in_b = 32'd1;
    @(negedge clock);
    check("bp_rdy1", 64'(in_ready), 64'd1);
    if (in_ready) sb.push_back(model(32'd1, 32'd1, 1'b0));
    @(posedge clock); #1;
    in_a = 32'd2; in_b = 32'd2;
    @(negedge clock);
    check("bp_rdy2", 64'(in_ready), 64'd1);
    if (in_ready) sb.push_back(model(32'd2, 32'd2, 1'b0));
    @(posedge clock); #1;
    in_a = 32'd3; in_b = 32'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("bp_rdy3", 64'(in_ready), 64'd0);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_sum", 64'(out_sum), 64'd2);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (i == 0) begin
        check("bp_rdy_release", 64'(in_ready), 64'd1);
        if (in_ready) sb.push_back(model(32'd3, 32'd3, 1'b0));
      end
      check("bp_consec_valid", 64'(out_valid), 64'd1);
      check("bp_consec_sum", 64'(out_sum), 64'(2 * (i + 1)));
      @(posedge clock); #1;
      if (i == 0) in_valid = 1'b0;
    end
    drain();

    // Async reset with two transactions in flight
    out_ready = 1'b0;
    send(32'd100, 32'd1, 1'b0);
    send(32'd200, 32'd2, 1'b0);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_sum", 64'(out_sum), 64'd0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("post_rst_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clock); #1;
    send(32'd10, 32'd20, 1'b0);
    drain();

    // Random traffic with random backpressure
    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    rand_ready = 0;
    @(posedge clock); #2;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_addsub_32.md
Name: pipe_addsub_32

Overview:
- Two-stage pipelined 32-bit add/subtract unit with valid/ready handshakes on both sides.
- Stage 1 forms per-bit and per-8-bit-block generate/propagate signals.
- Stage 2 is a 4-group carry-lookahead stage; it produces block carries and sums, then derives ALU flags.
- Sits in the ALU datapath; the multicycle mult/div unit can also use it as a shared adder.

Parameters:
WIDTH, 32, operand width; only 32 is supported
BLOCK_W, 8, bits per lookahead block; WIDTH/BLOCK_W must equal 4

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  operands and op presented
in_ready  out  1  unit can accept this cycle
in_a  in  32  operand A
in_b  in  32  operand B
in_sub  in  1  0 = A+B, 1 = A-B
out_valid  out  1  result registered and presented
out_ready  in  1  consumer accepts this cycle
out_sum  out  32  result
out_cout  out  1  carry out of bit 31
out_ovf  out  1  signed overflow
out_ne  out  1  A != B (subtract only, else 0)
out_lt  out  1  signed A < B (subtract only, else 0)

Behaviour:
- Reset (async assert, sync release):
  - s1_valid = 0, s2_valid = 0.
  - All output registers = 0; in_ready = 1 after reset.
  - A transaction in flight is discarded, not completed.
- Input transfer: occurs when in_valid && in_ready. Output transfer: occurs when out_valid && out_ready.
- Stage 1 captures:
  - Operand mapping: A; B' = in_sub ? ~in_b : in_b; cin = in_sub.
  - Per bit: g_i = a_i & b'_i, p_i = a_i ^ b'_i.
  - Per block k (0..3):
    - PG[k] = AND of the block's propagate bits.
    - GG[k] = block generate (lookahead within the block).
  - in_sub.
- Stage 2 computes:
  - Block carries: c0 = cin; c(k+1) = GG[k] | PG[k]&c(k), expanded in two-level sum-of-products form, with no ripple across blocks.
  - Sums: each block sum is formed from its p/g and carry-in c(k); out_cout = c4.
  - Overflow: out_ovf = carry into bit 31 XOR c4, for both add and subtract.
  - Subtract flags:
    - out_ne = |sum.
    - out_lt = sum[31] ^ ovf.
  - Add (in_sub = 0): out_ne = 0 and out_lt = 0.
- Pipeline advance:
  - s2 loads when s1_valid && (!s2_valid || out_ready).
  - s1 loads when in_valid && in_ready.
  - in_ready = !s1_valid || !s2_valid || out_ready.
  - Full throughput is one result per cycle with out_ready held high.
- Latency: input accepted at edge N produces out_valid = 1 after edge N+1, i.e. 2 cycles to output.
- Backpressure:
  - While out_valid && !out_ready, all out_* hold stable.
  - s1 may fill, then in_ready drops; at most 2 transactions are buffered.
  - No transaction is dropped or duplicated; results emerge in order.
- Simultaneous events:
  - Consume and accept in the same cycle both take effect.
  - When full with out_ready = 1, s1 advances into s2 and a new input enters s1 on the same edge.
- Idle: out_valid = 0; out_* data holds its last value and is don't-care.
- No combinational path from in_valid/in_a/in_b to out_*. in_ready depends combinationally only on out_ready and internal state.

Test Plan:
- 0x7FFFFFFF + 0x00000001, add -> sum 0x80000000, cout 0, ovf 1, ne 0, lt 0; out_valid two cycles after acceptance.
- 0xFFFFFFFF + 0x00000001, add -> sum 0x00000000, cout 1, ovf 0; this exercises the full carry chain across all 4 blocks.
- 5 - 7, sub -> sum 0xFFFFFFFE, cout 0, ovf 0, ne 1, lt 1. Then 9 - 9 -> sum 0, cout 1, ne 0, lt 0.
- 0x80000000 - 0x00000001, sub -> sum 0x7FFFFFFF, ovf 1, lt 1, ne 1.
- Backpressure: hold out_ready = 0 and offer 3 back-to-back adds (1+1, 2+2, 3+3).
  - Only 2 are accepted; in_ready = 0 on the third.
  - out_sum holds 2 stable.
  - Releasing out_ready gives outputs 2, 4, 6 in order on consecutive cycles.
- Reset: assert reset_n = 0 mid-stream with 2 transactions in flight -> out_valid drops immediately (async); after release in_ready = 1, no stale result appears, and a new 10+20 yields 30.
